// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// MULDIV_EN adds the MDU state and makes funct7=0000001 on R-type legal.
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
`ifdef MULDIV_EN
      , ST_MDU  = 3'd6
`endif
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   localparam logic [1:0] SRCA_PC   = 2'b00;
   localparam logic [1:0] SRCA_RS1  = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MEM = 2'b01;
   localparam logic [1:0] M2R_PC4 = 2'b10;

   localparam logic [1:0] PCSRC_PC4    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JAL    = 2'b10;
   localparam logic [1:0] PCSRC_JALR   = 2'b11;

   // Only BEQ/BNE are supported among the branches.
   function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3,
                                     input logic muldiv);
      logic legal;
      case (opcode)
`ifdef MULDIV_EN
         OPC_OP:     legal = 1'b1;
`else
         OPC_OP:     legal = !muldiv;
`endif
         OPC_BRANCH: legal = (funct3 == 3'b000) || (funct3 == 3'b001);
         OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC:
                     legal = 1'b1;
         default:    legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive wait cycles; expired fires on the cycle the count would reach TIMEOUT_CYCLES.
module ctrl_wait_timer #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic expired
);

   logic [7:0] count_r;

   assign expired = run && !clear && (count_r == 8'(TIMEOUT_CYCLES - 1));

   // Wait-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 8'd0;
      end else if (clear) begin
         count_r <= 8'd0;
      end else if (run && !expired) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB plus an absorbing TRAP.
// Define MULDIV_EN to add the MDU state and the mdu_start/mdu_done handshake.
module multicycle_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int ALUOP_W        = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic               clk,
   input  logic               rst,
`ifdef MULDIV_EN
   input  logic               mdu_done,
   output logic               mdu_start,
`endif
   output logic               imem_req,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   input  logic               dmem_ack,
   input  logic               alu_zero,
   output logic               ir_load,
   output logic               pc_write,
   output logic               reg_write,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         pc_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [2:0]         state_o,
   output logic               illegal_o,
   output logic               timeout_o
);

   state_t     state_r;
   logic [6:0] opcode_r;
   logic [2:0] funct3_r;
   logic [6:0] funct7_r;
   logic [4:0] rd_r;
   logic       illegal_r;
   logic       timeout_r;
   logic       wait_state_s;
   logic       ack_s;
   logic       expired_s;
   logic [3:0] alu_op4_s;
   logic       rd_nz_s;
   logic       unused_s;
`ifdef MULDIV_EN
   logic       mdu_first_r;
`endif

   assign unused_s     = ^imem_rdata[24:15];
   assign wait_state_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
   assign ack_s        = (state_r == ST_FETCH) ? imem_ack : dmem_ack;
   assign rd_nz_s      = (rd_r != 5'd0);
   assign state_o      = state_r;
   assign illegal_o    = illegal_r;
   assign timeout_o    = timeout_r;
   assign alu_op       = ALUOP_W'(alu_op4_s);

   ctrl_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (wait_state_s && !ack_s),
      .clear   (!wait_state_s || ack_s),
      .expired (expired_s)
   );

   // State register, latched instruction fields and sticky trap flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_FETCH;
         opcode_r  <= 7'd0;
         funct3_r  <= 3'd0;
         funct7_r  <= 7'd0;
         rd_r      <= 5'd0;
         illegal_r <= 1'b0;
         timeout_r <= 1'b0;
`ifdef MULDIV_EN
         mdu_first_r <= 1'b0;
`endif
      end else begin
`ifdef MULDIV_EN
         mdu_first_r <= 1'b0;
`endif
         case (state_r)
            ST_FETCH: begin
               if (imem_ack) begin
                  opcode_r <= imem_rdata[6:0];
                  rd_r     <= imem_rdata[11:7];
                  funct3_r <= imem_rdata[14:12];
                  funct7_r <= imem_rdata[31:25];
                  state_r  <= ST_DECODE;
               end else if (expired_s) begin
                  state_r   <= ST_TRAP;
                  timeout_r <= 1'b1;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_DECODE: begin
               if (is_legal(opcode_r, funct3_r, funct7_r == F7_MULDIV)) begin
                  state_r <= ST_EXEC;
               end else begin
                  state_r   <= ST_TRAP;
                  illegal_r <= 1'b1;
               end
            end
            ST_EXEC: begin
               case (opcode_r)
`ifdef MULDIV_EN
                  OPC_OP: begin
                     if (funct7_r == F7_MULDIV) begin
                        state_r     <= ST_MDU;
                        mdu_first_r <= 1'b1;
                     end else begin
                        state_r <= ST_WB;
                     end
                  end
                  OPC_OP_IMM, OPC_LUI, OPC_AUIPC: state_r <= ST_WB;
`else
                  OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: state_r <= ST_WB;
`endif
                  OPC_LOAD, OPC_STORE: state_r <= ST_MEM;
                  default:             state_r <= ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (dmem_ack) begin
                  state_r <= (opcode_r == OPC_LOAD) ? ST_WB : ST_FETCH;
               end else if (expired_s) begin
                  state_r   <= ST_TRAP;
                  timeout_r <= 1'b1;
               end else begin
                  state_r <= ST_MEM;
               end
            end
            ST_WB:   state_r <= ST_FETCH;
`ifdef MULDIV_EN
            ST_MDU:  state_r <= mdu_done ? ST_WB : ST_MDU;
`endif
            ST_TRAP: state_r <= ST_TRAP;
            default: state_r <= ST_TRAP;
         endcase
      end
   end

   // Datapath strobes and mux selects; reset decodes like TRAP so everything drops at once
   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_FOUR;
      mem_to_reg = M2R_ALU;
      pc_src     = PCSRC_PC4;
      alu_op4_s  = ALU_ADD;
`ifdef MULDIV_EN
      mdu_start  = 1'b0;
`endif
      case (rst ? ST_TRAP : state_r)
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ack;
            pc_write = imem_ack;
         end
         ST_DECODE: begin
            alu_src_b = SRCB_IMM;
         end
         ST_EXEC: begin
            case (opcode_r)
               OPC_OP: begin
                  alu_src_a = SRCA_RS1;
                  alu_src_b = SRCB_RS2;
                  alu_op4_s = {funct7_r[5], funct3_r};
               end
               OPC_OP_IMM: begin
                  alu_src_a = SRCA_RS1;
                  alu_src_b = SRCB_IMM;
                  // funct7[5] is only an opcode bit for SRAI; otherwise it is immediate data
                  alu_op4_s = {funct7_r[5] && (funct3_r == 3'b101), funct3_r};
               end
               OPC_LOAD, OPC_STORE: begin
                  alu_src_a = SRCA_RS1;
                  alu_src_b = SRCB_IMM;
               end
               OPC_BRANCH: begin
                  alu_src_a = SRCA_RS1;
                  alu_src_b = SRCB_RS2;
                  alu_op4_s = ALU_SUB;
                  pc_src    = PCSRC_BRANCH;
                  pc_write  = funct3_r[0] ? !alu_zero : alu_zero;
               end
               OPC_JAL, OPC_JALR: begin
                  alu_src_a  = SRCA_RS1;
                  alu_src_b  = SRCB_IMM;
                  pc_src     = (opcode_r == OPC_JAL) ? PCSRC_JAL : PCSRC_JALR;
                  pc_write   = 1'b1;
                  reg_write  = rd_nz_s;
                  mem_to_reg = M2R_PC4;
               end
               OPC_LUI: begin
                  alu_src_a = SRCA_ZERO;
                  alu_src_b = SRCB_IMM;
               end
               OPC_AUIPC: begin
                  alu_src_b = SRCB_IMM;
               end
               default: begin
                  alu_op4_s = ALU_ADD;
               end
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode_r == OPC_STORE);
         end
         ST_WB: begin
            reg_write  = rd_nz_s;
            mem_to_reg = (opcode_r == OPC_LOAD) ? M2R_MEM : M2R_ALU;
         end
`ifdef MULDIV_EN
         ST_MDU: begin
            mdu_start = mdu_first_r;
            alu_op4_s = {funct7_r[5], funct3_r};
         end
`endif
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench with a scoreboard queue, plus hand-written reset/timeout/trap sequences.
module tb_multicycle_control_unit;
   import riscv_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ack = 1'b0;
   logic        dmem_ack = 1'b0;
   logic        alu_zero = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_req, dmem_req, dmem_we, ir_load, pc_write, reg_write;
   logic        illegal_o, timeout_o;
   logic [1:0]  alu_src_a, alu_src_b, mem_to_reg, pc_src;
   logic [3:0]  alu_op;
   logic [2:0]  state_o;
`ifdef MULDIV_EN
   logic        mdu_start;
   logic        mdu_done = 1'b1;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.ALUOP_W(4), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .rst(rst),
`ifdef MULDIV_EN
      .mdu_done(mdu_done), .mdu_start(mdu_start),
`endif
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
      .ir_load(ir_load), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
      .alu_op(alu_op), .state_o(state_o), .illegal_o(illegal_o), .timeout_o(timeout_o)
   );

   typedef struct {
      string       name;
      logic [31:0] instr;
      int          mem_wait;
      logic        zero;
      int          lat;      // cycles spent outside FETCH after the fetch ack
      int          mem_cyc;  // cycles spent in MEM
      int          rw_state; // state where reg_write is seen (7 = never)
      logic        pcw;      // pc_write during EXEC
      logic [3:0]  aluop;    // alu_op during EXEC
      logic [1:0]  m2r;
      logic        we;
      logic        illegal;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(string name, logic [31:0] instr, int mem_wait, logic zero,
                               int lat, int mem_cyc, int rw_state, logic pcw,
                               logic [3:0] aluop, logic [1:0] m2r, logic we, logic illegal);
      vec_t v;
      v.name = name; v.instr = instr; v.mem_wait = mem_wait; v.zero = zero;
      v.lat = lat; v.mem_cyc = mem_cyc; v.rw_state = rw_state; v.pcw = pcw;
      v.aluop = aluop; v.m2r = m2r; v.we = we; v.illegal = illegal;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int         lat;
      int         mem_cyc;
      int         rw_state;
      int         bound;
      logic       pcw;
      logic       we;
      logic       strobes;
      logic [3:0] aop;
      logic [1:0] m2r;
      vec_t       e;
      lat = 0; mem_cyc = 0; rw_state = 7; bound = 0;
      pcw = 1'b0; we = 1'b0; strobes = 1'b0; aop = 4'hF; m2r = 2'b11;
      do_reset();
      alu_zero = v.zero;
      imem_rdata = v.instr;
      imem_ack = 1'b1;
      #1;
      check({v.name, "/fetch_strobes"}, {ir_load, pc_write, imem_req}, 3'b111);
      check({v.name, "/fetch_mux"}, {alu_src_a, alu_src_b, pc_src}, {SRCA_PC, SRCB_FOUR, PCSRC_PC4});
      sb.push_back(v);
      @(posedge clk); #1;
      imem_ack = 1'b0;
      while (state_o != 3'd0 && state_o != 3'd5 && bound < 40) begin
         lat++; bound++;
         if (state_o == 3'd2) begin aop = alu_op; pcw = pc_write; end
         if (reg_write) begin
            rw_state = (rw_state == 7) ? int'(state_o) : 6;
            m2r = mem_to_reg;
         end
         if (state_o == 3'd3) begin
            mem_cyc++;
            we = dmem_we;
            if (!dmem_req) strobes = 1'b1;
            dmem_ack = (mem_cyc == v.mem_wait + 1);
         end else begin
            dmem_ack = 1'b0;
         end
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      e = sb.pop_front();
      check({e.name, "/bounded"}, int'(bound < 40), 1);
      check({e.name, "/latency"}, lat, e.lat);
      check({e.name, "/illegal_o"}, illegal_o, e.illegal);
      check({e.name, "/rw_state"}, rw_state, e.rw_state);
      check({e.name, "/mem_cycles"}, mem_cyc, e.mem_cyc);
      if (e.illegal) begin
         check({e.name, "/trap_state"}, state_o, 5);
         imem_ack = 1'b1; dmem_ack = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            strobes = strobes | imem_req | dmem_req | dmem_we | ir_load | pc_write | reg_write;
         end
         check({e.name, "/trap_strobes"}, strobes, 0);
         check({e.name, "/trap_hold"}, {state_o, illegal_o}, {3'd5, 1'b1});
         imem_ack = 1'b0; dmem_ack = 1'b0;
      end else begin
         check({e.name, "/back_to_fetch"}, {state_o, imem_req}, {3'd0, 1'b1});
         check({e.name, "/alu_op"}, aop, e.aluop);
         check({e.name, "/pc_write_exec"}, pcw, e.pcw);
         if (e.rw_state != 7) check({e.name, "/mem_to_reg"}, m2r, e.m2r);
         if (e.mem_cyc > 0) begin
            check({e.name, "/dmem_we"}, we, e.we);
            check({e.name, "/dmem_req_held"}, strobes, 0);
         end
      end
   endtask

   initial begin
      //           name       instr         mw z  lat mem rw pcw aluop    m2r    we    ill
      vecs.push_back(mk("ADD",    32'h002081B3, 0, 0, 3, 0, 4, 0, 4'b0000, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("SUB",    32'h402081B3, 0, 0, 3, 0, 4, 0, 4'b1000, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("XORI",   32'h0070C293, 0, 0, 3, 0, 4, 0, 4'b0100, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("NOP_X0", 32'h00000013, 0, 0, 3, 0, 7, 0, 4'b0000, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("LUI",    32'h123452B7, 0, 0, 3, 0, 4, 0, 4'b0000, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("LW_W3",  32'h0080A203, 3, 0, 7, 4, 4, 0, 4'b0000, 2'b01, 1'b0, 1'b0));
      vecs.push_back(mk("LW_W0",  32'h0080A203, 0, 0, 4, 1, 4, 0, 4'b0000, 2'b01, 1'b0, 1'b0));
      vecs.push_back(mk("SW_W0",  32'h0020A223, 0, 0, 3, 1, 7, 0, 4'b0000, 2'b00, 1'b1, 1'b0));
      vecs.push_back(mk("SW_W2",  32'h0020A223, 2, 0, 5, 3, 7, 0, 4'b0000, 2'b00, 1'b1, 1'b0));
      vecs.push_back(mk("BEQ_Z1", 32'h00208463, 0, 1, 2, 0, 7, 1, 4'b1000, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("BEQ_Z0", 32'h00208463, 0, 0, 2, 0, 7, 0, 4'b1000, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("BNE_Z0", 32'h00209463, 0, 0, 2, 0, 7, 1, 4'b1000, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("BNE_Z1", 32'h00209463, 0, 1, 2, 0, 7, 0, 4'b1000, 2'b00, 1'b0, 1'b0));
      vecs.push_back(mk("JAL",    32'h010000EF, 0, 0, 2, 0, 2, 1, 4'b0000, 2'b10, 1'b0, 1'b0));
      vecs.push_back(mk("JALR",   32'h000100E7, 0, 0, 2, 0, 2, 1, 4'b0000, 2'b10, 1'b0, 1'b0));
      vecs.push_back(mk("OPC0",   32'h00000000, 0, 0, 1, 0, 7, 0, 4'b0000, 2'b00, 1'b0, 1'b1));
      vecs.push_back(mk("BLT",    32'h0020C463, 0, 0, 1, 0, 7, 0, 4'b0000, 2'b00, 1'b0, 1'b1));
`ifdef MULDIV_EN
      vecs.push_back(mk("MUL",    32'h027302B3, 0, 0, 4, 0, 4, 0, 4'b0000, 2'b00, 1'b0, 1'b0));
`else
      vecs.push_back(mk("MUL",    32'h027302B3, 0, 0, 1, 0, 7, 0, 4'b0000, 2'b00, 1'b0, 1'b1));
`endif

      // reset state while rst is held, then imem_req on the first cycle after release
      #12;
      check("reset_state", {state_o, imem_req, pc_write, reg_write, illegal_o, timeout_o}, {3'd0, 5'b00000});
      @(negedge clk); rst = 1'b0; #1;
      check("reset_release_imem_req", imem_req, 1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // imem_ack withheld 15 cycles -> TRAP with timeout_o
      do_reset();
      repeat (14) @(posedge clk);
      #1;
      check("timeout_pre", {state_o, timeout_o}, {3'd0, 1'b0});
      @(posedge clk); #1;
      check("timeout_trap", {state_o, timeout_o, imem_req}, {3'd5, 1'b1, 1'b0});
      #2 rst = 1'b1; #1;
      check("trap_async_reset", {state_o, timeout_o}, {3'd0, 1'b0});

      // ack on the 15th cycle wins over the timeout
      do_reset();
      repeat (14) @(posedge clk);
      #1;
      imem_rdata = 32'h002081B3; imem_ack = 1'b1;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      check("ack_on_timeout", {state_o, timeout_o}, {3'd1, 1'b0});

      // reset mid-MEM drops dmem_req at once; a late ack in FETCH is ignored
      do_reset();
      imem_rdata = 32'h0080A203; imem_ack = 1'b1;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      for (int i = 0; i < 6 && state_o != 3'd3; i++) begin @(posedge clk); #1; end
      check("reach_mem", {state_o, dmem_req}, {3'd3, 1'b1});
      #1 rst = 1'b1; #1;
      check("mem_async_reset", {state_o, dmem_req}, {3'd0, 1'b0});
      @(negedge clk); rst = 1'b0; dmem_ack = 1'b1;
      @(posedge clk); #1;
      check("late_dmem_ack", {state_o, dmem_req, imem_req}, {3'd0, 1'b0, 1'b1});
      dmem_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
